// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection datapath: stage codes, image size and
// window-geometry helpers used by the sequencer and the filter sub-modules.
package edge_pkg;

  localparam int unsigned IMG_DIM = 20;

  typedef enum logic [2:0] {
    StgIdle = 3'd0,
    StgMed  = 3'd1,
    StgGau  = 3'd2,
    StgSob  = 3'd3,
    StgNms  = 3'd4,
    StgHys  = 3'd5
  } stage_e;

  typedef enum logic [2:0] {
    StIdle,
    StRowStart,
    StScan,
    StDrain,
    StWbReq,
    StDone
  } seq_state_e;

  // Window edge length: Gaussian uses a 5x5 window, every other stage 3x3.
  function automatic int unsigned kdim(input stage_e s);
    return (s == StgGau) ? 32'd5 : 32'd3;
  endfunction

  // Valid window rows (and results per row) for a stage.
  function automatic int unsigned rows(input stage_e s);
    return IMG_DIM - kdim(s) + 32'd1;
  endfunction

  // Filter chain order; anything past hysteresis falls back to idle.
  function automatic stage_e next_stage(input stage_e s);
    case (s)
      StgMed:  return StgGau;
      StgGau:  return StgSob;
      StgSob:  return StgNms;
      StgNms:  return StgHys;
      default: return StgIdle;
    endcase
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Row/column/result counters for the raster scan, plus the register-file addresses
// derived from them: the top pixel of the presented column and the window centre of
// the next returned result.
module window_addr_gen #(
  parameter int unsigned IMG_DIM = edge_pkg::IMG_DIM,
  parameter int unsigned ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  edge_pkg::stage_e  stage,
  input  logic              frame_clr,
  input  logic              row_next,
  input  logic              col_step,
  input  logic              res_take,
  output logic              col_last,
  output logic              row_last,
  output logic              n_full,
  output logic [ADDR_W-1:0] col_addr,
  output logic [ADDR_W-1:0] wr_addr
);
  import edge_pkg::*;

  localparam int unsigned CW = $clog2(IMG_DIM);
  localparam logic [ADDR_W-1:0] DimA = ADDR_W'(IMG_DIM);

  logic [CW-1:0]     r_q, c_q, n_q;
  logic [CW-1:0]     n_max;
  logic [ADDR_W-1:0] r_a, c_a, n_a, h_a;
  logic              row_clr;

  // Per-stage geometry and address arithmetic; all unsigned ADDR_W, never wraps.
  always_comb begin
    n_max    = CW'(IMG_DIM - kdim(stage) + 32'd1);
    h_a      = ADDR_W'(kdim(stage) >> 1);
    r_a      = ADDR_W'(r_q);
    c_a      = ADDR_W'(c_q);
    n_a      = ADDR_W'(n_q);
    row_clr  = frame_clr || row_next;
    col_last = (c_q == CW'(IMG_DIM - 32'd1));
    row_last = (r_q == n_max - CW'(1));
    n_full   = (n_q == n_max);
    col_addr = r_a * DimA + c_a;
    wr_addr  = (r_a + h_a) * DimA + n_a + h_a;
  end

  // Counters: r restarts per stage, c and n restart on entry to every row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
      c_q <= '0;
      n_q <= '0;
    end else begin
      if (frame_clr) begin
        r_q <= '0;
      end else if (row_next) begin
        r_q <= r_q + CW'(1);
      end
      if (row_clr) begin
        c_q <= '0;
      end else if (col_step) begin
        c_q <= c_q + CW'(1);
      end
      if (row_clr) begin
        n_q <= '0;
      end else if (res_take) begin
        n_q <= n_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/edge_stage_sequencer.sv
// Top-level scheduler for the edge-detection filter chain: runs median, Gaussian,
// Sobel, non-max and hysteresis in turn, raster-scanning the image row by row and
// requesting a border/copy-back pass between stages.
module edge_stage_sequencer #(
  parameter int unsigned IMG_DIM = edge_pkg::IMG_DIM,
  parameter int unsigned ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              ksize5,
  output logic              mod_clr,
  output logic              col_valid,
  output logic [ADDR_W-1:0] col_addr,
  input  logic              res_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wb_req,
  input  logic              wb_ack,
  output logic              err
);
  import edge_pkg::*;

  seq_state_e        state_q;
  stage_e            stage_q;
  logic              frame_clr, row_next, col_step, accept_state;
  logic              col_last, row_last, n_full;
  logic [ADDR_W-1:0] col_addr_raw, wr_addr_raw;

  window_addr_gen #(
    .IMG_DIM (IMG_DIM),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .stage     (stage_q),
    .frame_clr (frame_clr),
    .row_next  (row_next),
    .col_step  (col_step),
    .res_take  (wr_en),
    .col_last  (col_last),
    .row_last  (row_last),
    .n_full    (n_full),
    .col_addr  (col_addr_raw),
    .wr_addr   (wr_addr_raw)
  );

  // Counter strobes and result acceptance decoded from the current state.
  always_comb begin
    frame_clr    = ((state_q == StIdle) && start) || ((state_q == StWbReq) && wb_ack);
    row_next     = (state_q == StDrain) && n_full && !row_last;
    col_step     = (state_q == StScan) && !col_last;
    accept_state = (state_q == StRowStart) || (state_q == StScan) || (state_q == StDrain);
    wr_en        = res_valid && accept_state && !n_full;
    // Addresses read as zero when not qualified so idle/reset values are clean.
    wr_addr      = wr_en ? wr_addr_raw : '0;
    col_addr     = col_valid ? col_addr_raw : '0;
    stage        = stage_q;
  end

  // Sequencer FSM with registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      stage_q   <= StgIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      ksize5    <= 1'b0;
      mod_clr   <= 1'b0;
      col_valid <= 1'b0;
      wb_req    <= 1'b0;
    end else begin
      mod_clr <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRowStart;
            stage_q <= StgMed;
            busy    <= 1'b1;
            ksize5  <= 1'b0;
            mod_clr <= 1'b1;
          end
        end
        StRowStart: begin
          state_q   <= StScan;
          col_valid <= 1'b1;
        end
        StScan: begin
          if (col_last) begin
            state_q   <= StDrain;
            col_valid <= 1'b0;
          end
        end
        StDrain: begin
          if (n_full) begin
            if (!row_last) begin
              state_q <= StRowStart;
              mod_clr <= 1'b1;
            end else if (stage_q == StgHys) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StWbReq;
              wb_req  <= 1'b1;
            end
          end
        end
        StWbReq: begin
          if (wb_ack) begin
            state_q <= StRowStart;
            wb_req  <= 1'b0;
            stage_q <= next_stage(stage_q);
            ksize5  <= (next_stage(stage_q) == StgGau);
            mod_clr <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          stage_q <= StgIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Sticky error: any result the sequencer cannot place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (res_valid && !wr_en) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_edge_stage_sequencer.sv
// Bench for edge_stage_sequencer: a latency-randomised model filter answers every
// window column, a random-delay write-back agent answers wb_req, and a reference
// model derived from the stage/row/column rules checks every address and pulse.
module tb_edge_stage_sequencer;

  localparam int D  = 20;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset, start, res_valid, wb_ack;
  logic          busy, done, ksize5, mod_clr, col_valid, wr_en, wb_req, err;
  logic [2:0]    stage;
  logic [AW-1:0] col_addr, wr_addr;

  edge_stage_sequencer #(
    .IMG_DIM (D),
    .ADDR_W  (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .ksize5    (ksize5),
    .mod_clr   (mod_clr),
    .col_valid (col_valid),
    .col_addr  (col_addr),
    .res_valid (res_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wb_req    (wb_req),
    .wb_ack    (wb_ack),
    .err       (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Window size and results per row, straight from the stage rules.
  function automatic int kd(input int s);
    return (s == 2) ? 5 : 3;
  endfunction
  function automatic int nres(input int s);
    return D - kd(s) + 1;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_stage"}, stage, 0);
    check_val({tag, "_ksize5"}, ksize5, 0);
    check_val({tag, "_mod_clr"}, mod_clr, 0);
    check_val({tag, "_col_valid"}, col_valid, 0);
    check_val({tag, "_col_addr"}, col_addr, 0);
    check_val({tag, "_wr_en"}, wr_en, 0);
    check_val({tag, "_wr_addr"}, wr_addr, 0);
    check_val({tag, "_wb_req"}, wb_req, 0);
    check_val({tag, "_err"}, err, 0);
  endtask

  // ---------------- model filter (res_valid driver) ----------------
  int q[$];
  int last_emit = -1;
  int rc = 0;
  int inject_at = -1;
  bit arm_inject = 0;
  bit inject_now = 0;

  initial begin
    int t;
    res_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      res_valid  = 1'b0;
      inject_now = 1'b0;
      if (reset) begin
        q.delete();
        rc = 0;
        last_emit = -1;
        inject_at = -1;
        continue;
      end
      if (mod_clr) rc = 0;
      if (col_valid) begin
        // A result exists once a full window of columns has been seen.
        if (rc >= (ksize5 ? 5 : 3) - 1) begin
          t = cyc + 3 + int'($urandom_range(0, 2));
          if (t <= last_emit) t = last_emit + 1;
          q.push_back(t);
          last_emit = t;
          if (arm_inject && rc == D - 1) begin
            inject_at  = t + 1;
            arm_inject = 0;
          end
        end
        rc++;
      end
      if (q.size() > 0 && q[0] == cyc) begin
        res_valid = 1'b1;
        void'(q.pop_front());
      end else if (inject_at == cyc) begin
        res_valid  = 1'b1;
        inject_now = 1'b1;
        inject_at  = -1;
      end
    end
  end

  // ---------------- write-back agent ----------------
  bit spur_ack = 0;
  bit hold_next = 1;
  bit holding = 0;
  bit post_check = 0;
  int wb_wait = -1;
  int hold_stage = 0;

  initial begin
    wb_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wb_ack = 1'b0;
      if (reset) begin
        wb_wait = -1;
        holding = 0;
        post_check = 0;
        continue;
      end
      if (post_check) begin
        check_val("hold_release_clr", mod_clr, 1);
        check_val("hold_release_stage", stage, hold_stage + 1);
        post_check = 0;
      end
      if (wb_req) begin
        if (wb_wait < 0) begin
          wb_wait    = hold_next ? 7 : int'($urandom_range(0, 3));
          holding    = hold_next;
          hold_next  = 0;
          hold_stage = stage;
        end
        if (holding && wb_wait > 0) begin
          check_val("hold_wb_req", wb_req, 1);
          check_val("hold_no_clr", mod_clr, 0);
          check_val("hold_stage", stage, hold_stage);
        end
        if (wb_wait == 0) begin
          wb_ack     = 1'b1;
          wb_wait    = -1;
          post_check = holding;
          holding    = 0;
        end else begin
          wb_wait--;
        end
      end else if (spur_ack) begin
        wb_ack   = 1'b1;
        spur_ack = 0;
      end
    end
  end

  // ---------------- reference model / monitor ----------------
  bit m_active = 0;
  bit m_open = 0;
  bit m_in_wb = 0;
  bit err_exp = 0;
  bit exp_wr;
  int m_stage = 0, m_row = 0, m_col = 0, m_res = 0, h = 0;
  int n_inj = 0, n_done = 0;
  int first_wr[6];
  int last_wr[6];

  task automatic row_done_check();
    check_val("row_cols", m_col, D);
    check_val("row_results", m_res, nres(m_stage));
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      first_wr[i] = -1;
      last_wr[i]  = -1;
    end
    forever begin
      @(negedge clk);
      if (reset) begin
        m_active = 0;
        err_exp  = 0;
        continue;
      end
      check_val("err", err, err_exp);
      if (inject_now) begin
        err_exp = 1;
        n_inj++;
      end
      exp_wr = res_valid && !inject_now;
      check_val("wr_en", wr_en, exp_wr);
      if (!m_active) begin
        check_val("idle_done", done, 0);
        check_val("idle_col_valid", col_valid, 0);
        continue;
      end
      if (mod_clr) begin
        if (m_in_wb) begin
          m_stage++;
          m_row   = 0;
          m_in_wb = 0;
        end else if (m_open) begin
          row_done_check();
          m_row++;
        end
        check_val("clr_stage", stage, m_stage);
        check_val("clr_ksize5", ksize5, (m_stage == 2));
        check_val("clr_busy", busy, 1);
        m_col  = 0;
        m_res  = 0;
        m_open = 1;
      end
      if (col_valid) begin
        check_val("col_addr", col_addr, m_row * D + m_col);
        m_col++;
      end
      if (exp_wr) begin
        h = kd(m_stage) / 2;
        check_val("wr_addr", wr_addr, (m_row + h) * D + m_res + h);
        if (m_stage >= 1 && m_stage <= 5) begin
          if (first_wr[m_stage] < 0) first_wr[m_stage] = wr_addr;
          last_wr[m_stage] = wr_addr;
        end
        m_res++;
      end
      if (wb_req && !m_in_wb) begin
        row_done_check();
        check_val("wb_rows", m_row, nres(m_stage) - 1);
        check_val("wb_stage", stage, m_stage);
        m_in_wb = 1;
        m_open  = 0;
      end
      if (done) begin
        row_done_check();
        check_val("done_rows", m_row, nres(m_stage) - 1);
        check_val("done_stages", m_stage, 5);
        m_active = 0;
        n_done++;
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic run_start();
    @(posedge clk);
    #1;
    start    = 1'b1;
    m_active = 1;
    m_stage  = 1;
    m_row    = 0;
    m_open   = 0;
    m_in_wb  = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_val("c1_busy", busy, 1);
    check_val("c1_mod_clr", mod_clr, 1);
    check_val("c1_stage", stage, 1);
    check_val("c1_col_valid", col_valid, 0);
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      check_val("c2_col_valid", col_valid, 1);
      check_val("c2_col_addr", col_addr, i);
    end
    @(negedge clk);
    check_val("scan_end_col_valid", col_valid, 0);
  endtask

  task automatic wait_stage_scan(input int s, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (stage == 3'(s) && col_valid) ok = 1;
    end
    check_val(tag, ok, 1);
  endtask

  task automatic wait_done(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    check_val(tag, ok, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_outputs_zero("idle");
    end

    // Pass 1: full run, with a held write-back, a stray ack, a busy start and an
    // extra result after a row is complete.
    run_start();
    spur_ack = 1;
    wait_stage_scan(3, "reach_sob");
    @(posedge clk);
    #1;
    start      = 1'b1;
    arm_inject = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_val("busy_start_stage", stage, 3);
    check_val("busy_start_busy", busy, 1);
    wait_done("pass1_done");
    @(negedge clk);
    check_val("post_done_busy", busy, 0);
    check_val("post_done_stage", stage, 0);
    check_val("post_done_pulse", done, 0);
    check_val("err_sticky", err, 1);
    check_val("inject_count", n_inj, 1);
    check_val("med_first_wr", first_wr[1], 21);
    check_val("med_last_wr", last_wr[1], 378);
    check_val("gau_first_wr", first_wr[2], 42);
    check_val("gau_last_wr", last_wr[2], 357);
    repeat (5) @(negedge clk);
    check_val("err_still_set", err, 1);

    // Pass 2: abort with an asynchronous reset during a non-max scan.
    run_start();
    wait_stage_scan(4, "reach_nms");
    repeat ($urandom_range(0, 8)) @(negedge clk);
    #2;
    reset    = 1'b1;
    m_active = 0;
    #1;
    check_outputs_zero("async_rst");
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero("rst_hold");
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_outputs_zero("post_rst_idle");
    end

    // Pass 3: clean restart after the abort.
    run_start();
    wait_done("pass3_done");
    @(negedge clk);
    check_val("done_count", n_done, 2);
    check_val("final_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
